bsg_fsb_multichannel_client: RTL and testbench

BSG_FSB_MULTICHANNEL_CLIENT -- requirements
Module: bsg_fsb_multichannel_client

---
 rtl/bsg_fsb_multichannel_client_if.sv | 29 ++
 rtl/bsg_fsb_multichannel_client.sv | 174 +++++++++++++++++
 tb/tb_bsg_fsb_multichannel_client.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/bsg_fsb_multichannel_client_if.sv
// bsg_fsb_multichannel_client_if: ring-side and per-channel handshake bundle for the multichannel FSB client
interface bsg_fsb_multichannel_client_if #(
  parameter int ring_width_p    = 80,
  parameter int num_channels_p  = 4,
  parameter int payload_width_p = 64
);
  logic                                      en_i;
  logic                                      v_i;
  logic [ring_width_p-1:0]                   data_i;
  logic                                      ready_o;
  logic                                      v_o;
  logic [ring_width_p-1:0]                   data_o;
  logic                                      yumi_i;
  logic [num_channels_p-1:0]                 ch_v_i;
  logic [num_channels_p*payload_width_p-1:0] ch_data_i;
  logic [num_channels_p-1:0]                 ch_ready_o;
  logic [num_channels_p-1:0]                 ch_v_o;
  logic [num_channels_p*payload_width_p-1:0] ch_data_o;
  logic [num_channels_p-1:0]                 ch_yumi_i;
  logic                                      err_o;
  modport slave (
    input  en_i, v_i, data_i, yumi_i, ch_v_i, ch_data_i, ch_yumi_i,
    output ready_o, v_o, data_o, ch_ready_o, ch_v_o, ch_data_o, err_o
  );
  modport master (
    output en_i, v_i, data_i, yumi_i, ch_v_i, ch_data_i, ch_yumi_i,
    input  ready_o, v_o, data_o, ch_ready_o, ch_v_o, ch_data_o, err_o
  );
endinterface

// File: rtl/bsg_fsb_multichannel_client.sv
// bsg_fsb_multichannel_client: credit-based multiplexing of N channels onto one FSB ring port
module bsg_fsb_multichannel_client #(
  parameter int ring_width_p     = 80,
  parameter int dest_id_p        = 0,
  parameter int num_channels_p   = 4,
  parameter int payload_width_p  = 64,
  parameter int remote_credits_p = 8
) (
  input logic clk_i,
  input logic reset_i,
  bsg_fsb_multichannel_client_if.slave bus
);
  localparam int n        = num_channels_p;
  localparam int p        = payload_width_p;
  localparam int c        = remote_credits_p;
  localparam int cw       = (n > 1) ? $clog2(n) : 1;
  localparam int crw      = $clog2(c + 1);
  localparam int aw       = (c > 1) ? $clog2(c) : 1;
  localparam int hi       = ring_width_p - 1;
  localparam int chan_lsb = ring_width_p - 6 - cw;
  localparam int pay_lsb  = chan_lsb - p;

  if (4 + 1 + 1 + cw + p > ring_width_p) begin : g_width_check
    $error("ring_width_p too narrow for header plus payload");
  end

  function automatic logic [cw-1:0] rot(input logic [cw-1:0] base, input int k);
    return cw'((int'(base) + k) % n);
  endfunction

  function automatic logic [ring_width_p-1:0] pack(input logic kind, input logic [cw-1:0] ch, input logic [p-1:0] pl);
    logic [ring_width_p-1:0] r;
    r = '0;
    r[hi -: 4] = 4'(dest_id_p);
    r[hi-5] = kind;
    r[chan_lsb +: cw] = ch;
    r[pay_lsb +: p] = pl;
    return r;
  endfunction

  logic                    ready_q, v_q, err_q;
  logic [ring_width_p-1:0] data_q;
  logic [cw-1:0]           ret_ptr, data_ptr, ret_win, data_win;
  logic                    any_ret, any_data, load, take_ret, take_data;
  logic [p-1:0]            sel_pay;
  logic [n-1:0]            data_elig, ret_elig, data_gnt, ret_gnt;
  logic [n-1:0]            drop_full, over_credit;
  logic                    in_fire, in_ours, in_kind, in_bad_chan, err_set;
  logic [cw-1:0]           in_chan;
  logic                    unused_pad;

  assign unused_pad = ^bus.data_i;

  assign in_fire     = bus.v_i & ready_q;
  assign in_ours     = in_fire & (bus.data_i[hi -: 4] == 4'(dest_id_p)) & ~bus.data_i[hi-4];
  assign in_kind     = bus.data_i[hi-5];
  assign in_chan     = bus.data_i[chan_lsb +: cw];
  assign in_bad_chan = int'(in_chan) >= n;

  assign load      = bus.en_i & ~reset_i & (~v_q | bus.yumi_i);
  assign take_ret  = load & any_ret;
  assign take_data = load & ~any_ret & any_data;
  assign data_gnt  = take_data ? (n'(1) << data_win) : '0;
  assign ret_gnt   = take_ret ? (n'(1) << ret_win) : '0;
  assign sel_pay   = bus.ch_data_i[data_win*p +: p];
  assign err_set   = (in_ours & in_bad_chan) | (|drop_full) | (|over_credit);

  assign bus.ready_o    = ready_q;
  assign bus.v_o        = v_q;
  assign bus.data_o     = data_q;
  assign bus.err_o      = err_q;
  assign bus.ch_ready_o = data_gnt;

  // round-robin search per class: lowest offset from the class pointer wins
  always_comb begin
    ret_win  = '0;
    data_win = '0;
    any_ret  = 1'b0;
    any_data = 1'b0;
    for (int k = n - 1; k >= 0; k--) begin
      if (ret_elig[rot(ret_ptr, k)]) begin
        any_ret = 1'b1;
        ret_win = rot(ret_ptr, k);
      end
      if (data_elig[rot(data_ptr, k)]) begin
        any_data = 1'b1;
        data_win = rot(data_ptr, k);
      end
    end
  end

  // output register: loads credit returns first, otherwise data; holds until yumi
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      v_q    <= 1'b0;
      data_q <= '0;
    end else if (load) begin
      v_q    <= any_ret | any_data;
      data_q <= take_ret ? pack(1'b1, ret_win, '0) : take_data ? pack(1'b0, data_win, sel_pay) : data_q;
    end else if (bus.yumi_i) begin
      v_q <= 1'b0;
    end
  end

  // round-robin pointers move past the winner only when their class is granted
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ret_ptr  <= '0;
      data_ptr <= '0;
    end else begin
      if (take_ret) ret_ptr <= rot(ret_win, 1);
      if (take_data) data_ptr <= rot(data_win, 1);
    end
  end

  // ring input opens on the first edge after reset and stays open
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) ready_q <= 1'b0;
    else ready_q <= 1'b1;
  end

  // sticky protocol error, cleared only by reset
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
  end

  for (genvar i = 0; i < n; i++) begin : g_ch
    logic [crw-1:0] credit, pend, cnt;
    logic [aw-1:0]  rd_ptr, wr_ptr;
    logic [p-1:0]   mem [c];
    logic           hit, data_in, ret_in, pop, full, wr_en;
    assign hit     = in_ours & ~in_bad_chan & (in_chan == cw'(i));
    assign data_in = hit & ~in_kind;
    assign ret_in  = hit & in_kind;
    assign pop     = bus.ch_yumi_i[i] & (cnt != '0);
    assign full    = cnt == crw'(c);
    assign wr_en   = data_in & (~full | pop);
    assign drop_full[i]   = data_in & full & ~pop;
    assign over_credit[i] = ret_in & (credit == crw'(c)) & ~data_gnt[i];
    assign data_elig[i]   = bus.ch_v_i[i] & (credit != '0);
    assign ret_elig[i]    = pend != '0;
    assign bus.ch_v_o[i]  = cnt != '0;
    assign bus.ch_data_o[i*p +: p] = mem[rd_ptr];
    // credits: returns add, granted data subtracts, saturate at the remote buffer depth
    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) credit <= crw'(c);
      else if (ret_in & ~data_gnt[i] & (credit != crw'(c))) credit <= credit + 1'b1;
      else if (data_gnt[i] & ~ret_in) credit <= credit - 1'b1;
    end
    // pending returns: each local pop owes the remote one credit
    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) pend <= '0;
      else if (pop & ~ret_gnt[i]) pend <= pend + 1'b1;
      else if (ret_gnt[i] & ~pop) pend <= pend - 1'b1;
    end
    // receive FIFO occupancy and pointers; push on full is allowed when a pop frees a slot
    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        cnt    <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (wr_en) wr_ptr <= (wr_ptr == aw'(c - 1)) ? '0 : wr_ptr + 1'b1;
        if (pop) rd_ptr <= (rd_ptr == aw'(c - 1)) ? '0 : rd_ptr + 1'b1;
        cnt <= cnt + crw'(wr_en) - crw'(pop);
      end
    end
    // receive FIFO storage
    always_ff @(posedge clk_i) begin
      if (wr_en) mem[wr_ptr] <= bus.data_i[pay_lsb +: p];
    end
  end
endmodule

// File: tb/tb_bsg_fsb_multichannel_client.sv
// tb_bsg_fsb_multichannel_client: scoreboard bench for the multichannel FSB client
module tb_bsg_fsb_multichannel_client;
  localparam logic [3:0] DEST = 4'd5;
  logic clk = 1'b0;
  logic rst;
  int vectors = 0, miscompares = 0, got = 0;
  logic [79:0] exp_q[$];
  logic [79:0] e_pkt;

  bsg_fsb_multichannel_client_if #(.ring_width_p(80), .num_channels_p(4), .payload_width_p(64)) bus();
  bsg_fsb_multichannel_client_if #(.ring_width_p(80), .num_channels_p(3), .payload_width_p(64)) bus3();

  bsg_fsb_multichannel_client #(.ring_width_p(80), .dest_id_p(5), .num_channels_p(4), .payload_width_p(64), .remote_credits_p(8))
    dut (.clk_i(clk), .reset_i(rst), .bus(bus));
  // a 3-channel instance: with 4 channels the 2-bit chan field cannot encode an out-of-range index
  bsg_fsb_multichannel_client #(.ring_width_p(80), .dest_id_p(5), .num_channels_p(3), .payload_width_p(64), .remote_credits_p(8))
    dut3 (.clk_i(clk), .reset_i(rst), .bus(bus3));

  always #5 clk = ~clk;

  function automatic logic [79:0] mk(input logic [3:0] d, input logic cmd, input logic kind, input logic [1:0] ch, input logic [63:0] pl);
    return {d, cmd, kind, ch, pl, 8'h00};
  endfunction

  // scoreboard consumer: every accepted outbound packet must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && bus.v_o && bus.yumi_i) begin
      vectors++;
      got++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL out_unexpected data_o=%h expected none", bus.data_o);
      end else begin
        e_pkt = exp_q.pop_front();
        if (bus.data_o !== e_pkt) begin
          miscompares++;
          $display("FAIL out_packet data_o=%h expected %h", bus.data_o, e_pkt);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.en_i = 0; bus.v_i = 0; bus.data_i = '0; bus.yumi_i = 0;
    bus.ch_v_i = '0; bus.ch_data_i = '0; bus.ch_yumi_i = '0;
    bus3.en_i = 0; bus3.v_i = 0; bus3.data_i = '0; bus3.yumi_i = 0;
    bus3.ch_v_i = '0; bus3.ch_data_i = '0; bus3.ch_yumi_i = '0;
  endtask

  task automatic pulse_reset();
    idle_inputs();
    @(negedge clk);
    rst = 1;
    tick();
    rst = 0;
    tick();
  endtask

  task automatic send(input logic [79:0] pkt);
    bus.v_i = 1; bus.data_i = pkt;
    tick();
    bus.v_i = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    bus.en_i = 1; bus.ch_v_i = '1;
    #12;
    vectors++; if (bus.v_o !== 1'b0) begin miscompares++; $display("FAIL rst_v_o got=%b want=0", bus.v_o); end
    vectors++; if (bus.ready_o !== 1'b0) begin miscompares++; $display("FAIL rst_ready got=%b want=0", bus.ready_o); end
    vectors++; if (bus.ch_ready_o !== 4'b0) begin miscompares++; $display("FAIL rst_ch_ready got=%b want=0", bus.ch_ready_o); end
    vectors++; if (bus.ch_v_o !== 4'b0 || bus.err_o !== 1'b0) begin miscompares++; $display("FAIL rst_chv_err got=%b/%b want=0/0", bus.ch_v_o, bus.err_o); end
    idle_inputs();
    tick();
    rst = 0;
    #1;
    vectors++; if (bus.ready_o !== 1'b0) begin miscompares++; $display("FAIL ready_before_edge got=%b want=0", bus.ready_o); end
    tick();
    vectors++; if (bus.ready_o !== 1'b1) begin miscompares++; $display("FAIL ready_after_edge got=%b want=1", bus.ready_o); end
  endtask

  task automatic test_credits();
    int g0;
    pulse_reset();
    g0 = got;
    bus.ch_data_i[128 +: 64] = 64'hC0FF_EE00_0000_0002;
    bus.ch_v_i[2] = 1; bus.en_i = 1; bus.yumi_i = 1;
    for (int k = 0; k < 8; k++) exp_q.push_back(mk(DEST, 0, 0, 2, 64'hC0FF_EE00_0000_0002));
    repeat (14) tick();
    vectors++; if (got - g0 !== 8) begin miscompares++; $display("FAIL credit_burst got=%0d want=8", got - g0); end
    @(negedge clk);
    vectors++; if (bus.ch_ready_o[2] !== 1'b0) begin miscompares++; $display("FAIL credit_empty_ready got=%b want=0", bus.ch_ready_o[2]); end
    tick();
    exp_q.push_back(mk(DEST, 0, 0, 2, 64'hC0FF_EE00_0000_0002));
    send(mk(DEST, 0, 1, 2, 64'h0));
    repeat (6) tick();
    vectors++; if (got - g0 !== 9) begin miscompares++; $display("FAIL credit_return_one got=%0d want=9", got - g0); end
    vectors++; if (exp_q.size() !== 0) begin miscompares++; $display("FAIL credit_queue left=%0d want=0", exp_q.size()); end
    bus.ch_v_i = '0;
  endtask

  task automatic test_round_robin();
    int ord [5] = '{0, 1, 2, 3, 0};
    pulse_reset();
    for (int i = 0; i < 4; i++) bus.ch_data_i[i*64 +: 64] = 64'hDA7A_0000_0000_0000 + 64'(i);
    for (int k = 0; k < 5; k++) exp_q.push_back(mk(DEST, 0, 0, 2'(ord[k]), 64'hDA7A_0000_0000_0000 + 64'(ord[k])));
    bus.en_i = 1; bus.yumi_i = 1; bus.ch_v_i = '1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      vectors++; if (bus.ch_ready_o !== 4'(1 << ord[k])) begin miscompares++; $display("FAIL rr_grant%0d got=%b want=%b", k, bus.ch_ready_o, 4'(1 << ord[k])); end
      vectors++; if (bus.v_o !== (k > 0)) begin miscompares++; $display("FAIL rr_latency%0d v_o=%b want=%b", k, bus.v_o, k > 0); end
      tick();
    end
    bus.ch_v_i = '0;
    repeat (3) tick();
    vectors++; if (exp_q.size() !== 0) begin miscompares++; $display("FAIL rr_queue left=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_returns();
    logic [63:0] pl [3] = '{64'h11, 64'h22, 64'h33};
    int g0;
    pulse_reset();
    bus.yumi_i = 1;
    for (int k = 0; k < 3; k++) send(mk(DEST, 0, 0, 1, pl[k]));
    send(mk(DEST, 1, 0, 3, 64'hBAD));
    send(mk(4'd6, 0, 0, 3, 64'hBAD));
    vectors++; if (bus.ch_v_o !== 4'b0010 || bus.err_o !== 1'b0) begin miscompares++; $display("FAIL rx_fill ch_v_o=%b err=%b want=0010/0", bus.ch_v_o, bus.err_o); end
    bus.ch_data_i[63:0] = 64'hF00D; bus.ch_v_i[0] = 1;
    for (int k = 0; k < 3; k++) begin
      bus.ch_yumi_i[1] = 1;
      @(negedge clk);
      vectors++; if (bus.ch_data_o[64 +: 64] !== pl[k]) begin miscompares++; $display("FAIL rx_head%0d got=%h want=%h", k, bus.ch_data_o[64 +: 64], pl[k]); end
      tick();
    end
    bus.ch_yumi_i = '0;
    vectors++; if (bus.ch_v_o[1] !== 1'b0) begin miscompares++; $display("FAIL rx_drained got=%b want=0", bus.ch_v_o[1]); end
    g0 = got;
    for (int k = 0; k < 3; k++) exp_q.push_back(mk(DEST, 0, 1, 1, 64'h0));
    exp_q.push_back(mk(DEST, 0, 0, 0, 64'hF00D));
    bus.en_i = 1;
    repeat (4) tick();
    bus.en_i = 0; bus.ch_v_i = '0;
    repeat (3) tick();
    vectors++; if (got - g0 !== 4 || exp_q.size() !== 0) begin miscompares++; $display("FAIL returns_count got=%0d left=%0d want=4/0", got - g0, exp_q.size()); end
  endtask

  task automatic test_bad_chan();
    pulse_reset();
    bus3.v_i = 1; bus3.data_i = mk(DEST, 0, 0, 3, 64'h5);
    tick();
    bus3.v_i = 0;
    vectors++; if (bus3.err_o !== 1'b1) begin miscompares++; $display("FAIL badchan_err got=%b want=1", bus3.err_o); end
    vectors++; if (bus3.ch_v_o !== 3'b0) begin miscompares++; $display("FAIL badchan_fifo got=%b want=000", bus3.ch_v_o); end
    vectors++; if (bus.err_o !== 1'b0) begin miscompares++; $display("FAIL badchan_other got=%b want=0", bus.err_o); end
  endtask

  task automatic test_overflow();
    pulse_reset();
    for (int k = 0; k < 8; k++) send(mk(DEST, 0, 0, 0, 64'(k)));
    bus.ch_yumi_i[0] = 1;
    send(mk(DEST, 0, 0, 0, 64'd8));
    bus.ch_yumi_i = '0;
    vectors++; if (bus.err_o !== 1'b0) begin miscompares++; $display("FAIL full_pushpop_err got=%b want=0", bus.err_o); end
    send(mk(DEST, 0, 0, 0, 64'd9));
    vectors++; if (bus.err_o !== 1'b1) begin miscompares++; $display("FAIL overflow_err got=%b want=1", bus.err_o); end
    for (int k = 0; k < 8; k++) begin
      bus.ch_yumi_i[0] = 1;
      @(negedge clk);
      vectors++; if (bus.ch_data_o[63:0] !== 64'(k + 1)) begin miscompares++; $display("FAIL ovf_head%0d got=%h want=%h", k, bus.ch_data_o[63:0], 64'(k + 1)); end
      tick();
    end
    bus.ch_yumi_i = '0;
    vectors++; if (bus.ch_v_o[0] !== 1'b0 || bus.err_o !== 1'b1) begin miscompares++; $display("FAIL ovf_end ch_v=%b err=%b want=0/1", bus.ch_v_o[0], bus.err_o); end
  endtask

  task automatic test_excess_credit();
    int g0;
    pulse_reset();
    send(mk(DEST, 0, 1, 1, 64'h0));
    vectors++; if (bus.err_o !== 1'b1) begin miscompares++; $display("FAIL excess_err got=%b want=1", bus.err_o); end
    g0 = got;
    for (int k = 0; k < 8; k++) exp_q.push_back(mk(DEST, 0, 0, 1, 64'hABCD));
    bus.ch_data_i[64 +: 64] = 64'hABCD; bus.ch_v_i[1] = 1; bus.en_i = 1; bus.yumi_i = 1;
    repeat (14) tick();
    bus.ch_v_i = '0;
    vectors++; if (got - g0 !== 8) begin miscompares++; $display("FAIL excess_saturate got=%0d want=8", got - g0); end
  endtask

  task automatic test_reset_midop();
    int g0;
    pulse_reset();
    bus.ch_data_i[192 +: 64] = 64'h3333; bus.ch_v_i[3] = 1; bus.en_i = 1;
    tick();
    repeat (2) tick();
    @(negedge clk);
    vectors++; if (bus.v_o !== 1'b1 || bus.data_o !== mk(DEST, 0, 0, 3, 64'h3333)) begin miscompares++; $display("FAIL held_pkt v=%b data=%h want 1/%h", bus.v_o, bus.data_o, mk(DEST, 0, 0, 3, 64'h3333)); end
    vectors++; if (bus.ch_ready_o !== 4'b0) begin miscompares++; $display("FAIL held_no_load got=%b want=0", bus.ch_ready_o); end
    rst = 1;
    #1;
    vectors++; if (bus.v_o !== 1'b0 || bus.ready_o !== 1'b0) begin miscompares++; $display("FAIL async_reset v=%b ready=%b want=0/0", bus.v_o, bus.ready_o); end
    tick();
    rst = 0;
    bus.yumi_i = 1;
    g0 = got;
    for (int k = 0; k < 8; k++) exp_q.push_back(mk(DEST, 0, 0, 3, 64'h3333));
    #1;
    vectors++; if (bus.ready_o !== 1'b0) begin miscompares++; $display("FAIL midop_ready_pre got=%b want=0", bus.ready_o); end
    tick();
    vectors++; if (bus.ready_o !== 1'b1) begin miscompares++; $display("FAIL midop_ready_post got=%b want=1", bus.ready_o); end
    repeat (14) tick();
    bus.ch_v_i = '0;
    vectors++; if (got - g0 !== 8 || exp_q.size() !== 0) begin miscompares++; $display("FAIL midop_credits got=%0d left=%0d want=8/0", got - g0, exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_credits();
    test_round_robin();
    test_returns();
    test_bad_chan();
    test_overflow();
    test_excess_credit();
    test_reset_midop();
    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
